reg_file8x16: RTL and testbench
===============================

# reg_file8x16

Eight-entry, 16-bit register file feeding the 8-way 16-bit read multiplexer stage of the datapath. It provides one synchronous write port, two combinational read ports with write-through bypass, a per-register dirty mask, and a sequenced clear engine that zeroes the file one register per cycle. Read selection uses the same 3-bit `lines` encoding as the downstream 8-way mux: index 0 is `inp1`, index 7 is `inp8`.

## Interface

Parameters:
- `WIDTH`, default 16: data width of each register. Only 16 is required and verified.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `inp`, input, WIDTH: write data.
- `wr_en`, input, 1: write strobe.
- `wr_line`, input, 3: write register index.
- `rd_line_a`, input, 3: read index, port A.
- `rd_line_b`, input, 3: read index, port B.
- `clr`, input, 1: single-cycle request to start a clear sequence.
- `out_a`, output, WIDTH: port A read data, combinational.
- `out_b`, output, WIDTH: port B read data, combinational.
- `busy`, output, 1: clear sequence in progress. Registered.
- `dirty`, output, 8: bit i is set when register i has been written since the last reset or clear. Registered.

## Operation

- Storage is `reg[0..7]`, each WIDTH bits wide.
- The state machine has two states, IDLE and CLEARING, plus a 3-bit clear counter `cnt`.

IDLE:
- If `clr`=1: go to CLEARING with `cnt`=0 and `busy`=1. A `wr_en` asserted in the same cycle is dropped, because `clr` has priority.
- Else if `wr_en`=1: `reg[wr_line]` ← `inp` and `dirty[wr_line]` ← 1.

CLEARING:
- Each cycle: `reg[cnt]` ← 0, `dirty[cnt]` ← 0, `cnt` ← `cnt`+1.
- On the edge that clears `reg[7]`: go to IDLE with `busy`=0.
- `wr_en` and `clr` are ignored while `busy`=1. They are not queued.

Reads:
- `out_a` = `reg[rd_line_a]`, and likewise for port B.
- Bypass: when `wr_en`=1, `busy`=0, `clr`=0 and `wr_line`==`rd_line_x`, then `out_x` = `inp` (write-through, same cycle).
- During CLEARING there is no bypass. Reads return current contents: already-cleared registers read 0, the rest read their old values.
- Both ports may select the same index and must return identical data.

Reset (`rst_n`=0, asynchronous, effective immediately):
- All `reg` = 0, `dirty` = 8'h00, `busy` = 0, `cnt` = 0, state IDLE.
- `out_a` and `out_b` therefore read 0 unless bypass is active.
- Reset asserted mid-clear aborts the sequence.
- On release, the block is in IDLE and the first rising edge may write.

## Timing

- Write latency: data presented at edge N is readable without bypass from edge N onward, i.e. in cycle N+1.
- Bypass read latency: 0 cycles (combinational from `inp`, `wr_en`, `wr_line`).
- Clear timing:
  - `clr` sampled at edge N raises `busy` after edge N.
  - Edges N+1 through N+8 clear `reg[0]` through `reg[7]`.
  - `busy` falls after edge N+8.
  - Total: 8 busy cycles.
- First write accepted after a clear: the edge N+9.
- `dirty` and `busy` change only on clock edges or on async reset. No combinational path from inputs to either.
- `cnt` wraps from 7 to 0 on the final clear edge. It is never observed outside CLEARING.

## Test plan

- **Reset:** hold `rst_n`=0 for 2 cycles, then release → `out_a`=`out_b`=0 for every index, `dirty`=00, `busy`=0.
- **Write/read and bypass:**
  - Write 16'hBEEF to index 3.
  - Same cycle, `rd_line_a`=3 → `out_a`=BEEF via bypass.
  - Next cycle, `wr_en`=0 → `out_a`=BEEF and `dirty`=8'h08.
  - `rd_line_b`=4 → 0.
- **Fill and dual read:**
  - Write 16'h1000+i to each index i over 8 cycles → `dirty`=FF.
  - Sweep `rd_line_a`=i with `rd_line_b`=7-i → correct values on both ports, and equal values when the indices match.
- **Clear sequence:**
  - From the filled state, pulse `clr` → `busy` is high for exactly 8 cycles.
  - On the 3rd busy cycle, `reg[0..1]`=0, `reg[2]` still reads 16'h1002, `reg[3..7]` hold their old values, and `dirty`=FC.
  - After `busy` falls, all registers read 0 and `dirty`=00.
- **Ignored inputs during busy:** during CLEARING, assert `wr_en` to index 7 with 16'hAAAA and pulse `clr` again → `reg[7]` ends at 0, no bypass occurs, and `busy` still ends after 8 cycles.
- **Priority and mid-clear reset:**
  - Assert `clr` and `wr_en` (index 1, 16'h5555) together → the write is dropped and `dirty[1]`=0.
  - Assert `rst_n`=0 at the 4th busy cycle → `busy`=0 immediately, all registers read 0, and a write on the first edge after release succeeds.

Source files
------------

// File: rtl/reg_file8x16.sv
// Eight-entry register file with write-through bypass, per-register dirty mask
// and a sequenced clear engine that zeroes one register per cycle.
module reg_file8x16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inp,
    input  logic             wr_en,
    input  logic [2:0]       wr_line,
    input  logic [2:0]       rd_line_a,
    input  logic [2:0]       rd_line_b,
    input  logic             clr,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             busy,
    output logic [7:0]       dirty
);
    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic [WIDTH-1:0] r_mem [8];
    logic [7:0]       r_dirty;
    logic             w_wr;
    logic             w_clr_step;
    logic             w_byp_a;
    logic             w_byp_b;

    // clr wins over a same-cycle write; both are ignored while clearing
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr        = 1'b0;
        w_clr_step  = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_state_nxt = CLEARING;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_wr = wr_en;
                end
            end
            CLEARING: begin
                w_clr_step = 1'b1;
                w_cnt_nxt  = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
            r_dirty <= 8'h00;
        end else if (w_wr) begin
            r_mem[wr_line]   <= inp;
            r_dirty[wr_line] <= 1'b1;
        end else if (w_clr_step) begin
            r_mem[r_cnt]   <= '0;
            r_dirty[r_cnt] <= 1'b0;
        end
    end

    // Bypass only when the write will actually land on this edge
    assign w_byp_a = w_wr && (wr_line == rd_line_a);
    assign w_byp_b = w_wr && (wr_line == rd_line_b);

    assign out_a = w_byp_a ? inp : r_mem[rd_line_a];
    assign out_b = w_byp_b ? inp : r_mem[rd_line_b];
    assign busy  = (r_state == CLEARING);
    assign dirty = r_dirty;

endmodule

// File: tb/tb_reg_file8x16.sv
// Scoreboard bench for reg_file8x16: expected read data is queued when the read
// indices are driven and popped when the outputs are sampled.
`timescale 1ns/1ps
module tb_reg_file8x16;
    logic        clk;
    logic        rst_n;
    logic [15:0] inp;
    logic        wr_en;
    logic [2:0]  wr_line;
    logic [2:0]  rd_line_a;
    logic [2:0]  rd_line_b;
    logic        clr;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        busy;
    logic [7:0]  dirty;

    int pass_cnt;
    int total_cnt;
    logic [15:0] model [8];
    logic [15:0] sb_q [$];

    reg_file8x16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inp       (inp),
        .wr_en     (wr_en),
        .wr_line   (wr_line),
        .rd_line_a (rd_line_a),
        .rd_line_b (rd_line_b),
        .clr       (clr),
        .out_a     (out_a),
        .out_b     (out_b),
        .busy      (busy),
        .dirty     (dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            rd_line_a = 3'(i);
            rd_line_b = 3'(7 - i);
            sb_q.push_back(model[i]);
            sb_q.push_back(model[7 - i]);
            #0.5;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_a !== e) $display("FAIL reset_out_a[%0d] got %h want %h", i, out_a, e);
            else pass_cnt++;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_b !== e) $display("FAIL reset_out_b[%0d] got %h want %h", 7 - i, out_b, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (dirty !== 8'h00) $display("FAIL reset_dirty got %h want 00", dirty);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_write_bypass();
        logic [15:0] e;
        step();
        wr_en = 1'b1; wr_line = 3'd3; inp = 16'hBEEF;
        rd_line_a = 3'd3; rd_line_b = 3'd4;
        sb_q.push_back(16'hBEEF);
        sb_q.push_back(model[4]);
        #1;
        e = sb_q.pop_front();
        total_cnt++;
        if (out_a !== e) $display("FAIL bypass_a got %h want %h", out_a, e);
        else pass_cnt++;
        e = sb_q.pop_front();
        total_cnt++;
        if (out_b !== e) $display("FAIL bypass_b_other got %h want %h", out_b, e);
        else pass_cnt++;
        step();
        model[3] = 16'hBEEF;
        wr_en = 1'b0; inp = 16'h0000;
        sb_q.push_back(model[3]);
        #1;
        e = sb_q.pop_front();
        total_cnt++;
        if (out_a !== e) $display("FAIL stored_a got %h want %h", out_a, e);
        else pass_cnt++;
        total_cnt++;
        if (dirty !== 8'h08) $display("FAIL write_dirty got %h want 08", dirty);
        else pass_cnt++;
        total_cnt++;
        if (out_b !== 16'h0000) $display("FAIL unwritten_b got %h want 0000", out_b);
        else pass_cnt++;
    endtask

    task automatic test_fill_dual_read();
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_line = 3'(i); inp = 16'h1000 + 16'(i);
            step();
            model[i] = 16'h1000 + 16'(i);
        end
        wr_en = 1'b0;
        #1;
        total_cnt++;
        if (dirty !== 8'hFF) $display("FAIL fill_dirty got %h want FF", dirty);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            rd_line_a = 3'(i);
            rd_line_b = 3'(7 - i);
            sb_q.push_back(model[i]);
            sb_q.push_back(model[7 - i]);
            #0.5;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_a !== e) $display("FAIL fill_a[%0d] got %h want %h", i, out_a, e);
            else pass_cnt++;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_b !== e) $display("FAIL fill_b[%0d] got %h want %h", 7 - i, out_b, e);
            else pass_cnt++;
        end
        step();
        for (int i = 0; i < 8; i++) begin
            rd_line_a = 3'(i);
            rd_line_b = 3'(i);
            sb_q.push_back(model[i]);
            #0.5;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_a !== e || out_b !== e)
                $display("FAIL same_index[%0d] got a=%h b=%h want %h", i, out_a, out_b, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear();
        logic [15:0] e;
        int nbusy;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 20) begin
            nbusy++;
            if (nbusy == 3) begin
                for (int i = 0; i < 8; i++) begin
                    rd_line_a = 3'(i);
                    rd_line_b = 3'(7 - i);
                    sb_q.push_back((i < 2) ? 16'h0000 : model[i]);
                    sb_q.push_back((7 - i < 2) ? 16'h0000 : model[7 - i]);
                    #0.5;
                    e = sb_q.pop_front();
                    total_cnt++;
                    if (out_a !== e) $display("FAIL midclear_a[%0d] got %h want %h", i, out_a, e);
                    else pass_cnt++;
                    e = sb_q.pop_front();
                    total_cnt++;
                    if (out_b !== e) $display("FAIL midclear_b[%0d] got %h want %h", 7 - i, out_b, e);
                    else pass_cnt++;
                end
                total_cnt++;
                if (dirty !== 8'hFC) $display("FAIL midclear_dirty got %h want FC", dirty);
                else pass_cnt++;
            end
            step();
        end
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        total_cnt++;
        if (nbusy != 8) $display("FAIL clear_busy_cycles got %0d want 8", nbusy);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            rd_line_a = 3'(i);
            sb_q.push_back(model[i]);
            #0.5;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_a !== e) $display("FAIL cleared_a[%0d] got %h want %h", i, out_a, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (dirty !== 8'h00) $display("FAIL cleared_dirty got %h want 00", dirty);
        else pass_cnt++;
    endtask

    task automatic test_ignored_while_busy();
        logic [15:0] e;
        int nbusy;
        step();
        wr_en = 1'b1; wr_line = 3'd7; inp = 16'h1234;
        step();
        model[7] = 16'h1234;
        wr_en = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        rd_line_a = 3'd7;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 20) begin
            nbusy++;
            if (nbusy == 2) begin
                wr_en = 1'b1; wr_line = 3'd7; inp = 16'hAAAA;
                clr = 1'b1;
            end else begin
                clr = 1'b0;
            end
            sb_q.push_back(model[7]);
            #1;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_a !== e) $display("FAIL busy_no_bypass[%0d] got %h want %h", nbusy, out_a, e);
            else pass_cnt++;
            step();
        end
        wr_en = 1'b0; clr = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        total_cnt++;
        if (nbusy != 8) $display("FAIL ignored_busy_cycles got %0d want 8", nbusy);
        else pass_cnt++;
        sb_q.push_back(model[7]);
        #1;
        e = sb_q.pop_front();
        total_cnt++;
        if (out_a !== e) $display("FAIL ignored_reg7 got %h want %h", out_a, e);
        else pass_cnt++;
        total_cnt++;
        if (dirty !== 8'h00) $display("FAIL ignored_dirty got %h want 00", dirty);
        else pass_cnt++;
    endtask

    task automatic test_priority_mid_reset();
        logic [15:0] e;
        step();
        wr_en = 1'b1; wr_line = 3'd5; inp = 16'h7777;
        step();
        model[5] = 16'h7777;
        clr = 1'b1; wr_en = 1'b1; wr_line = 3'd1; inp = 16'h5555;
        rd_line_a = 3'd1;
        sb_q.push_back(model[1]);
        #1;
        e = sb_q.pop_front();
        total_cnt++;
        if (out_a !== e) $display("FAIL prio_no_bypass got %h want %h", out_a, e);
        else pass_cnt++;
        step();
        clr = 1'b0; wr_en = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL prio_busy got %b want 1", busy);
        else pass_cnt++;
        total_cnt++;
        if (dirty !== 8'h20) $display("FAIL prio_dirty got %h want 20", dirty);
        else pass_cnt++;
        step();
        step();
        step();
        rd_line_a = 3'd5;
        sb_q.push_back(model[5]);
        #0.5;
        e = sb_q.pop_front();
        total_cnt++;
        if (out_a !== e || busy !== 1'b1)
            $display("FAIL busy4_reg5 got %h busy=%b want %h busy=1", out_a, busy, e);
        else pass_cnt++;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        #0.5;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (dirty !== 8'h00) $display("FAIL midreset_dirty got %h want 00", dirty);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            rd_line_a = 3'(i);
            sb_q.push_back(model[i]);
            #0.5;
            e = sb_q.pop_front();
            total_cnt++;
            if (out_a !== e) $display("FAIL midreset_a[%0d] got %h want %h", i, out_a, e);
            else pass_cnt++;
        end
        step();
        rst_n = 1'b1;
        wr_en = 1'b1; wr_line = 3'd6; inp = 16'h6666;
        step();
        model[6] = 16'h6666;
        wr_en = 1'b0; inp = 16'h0000;
        rd_line_a = 3'd6;
        sb_q.push_back(model[6]);
        #1;
        e = sb_q.pop_front();
        total_cnt++;
        if (out_a !== e) $display("FAIL post_reset_write got %h want %h", out_a, e);
        else pass_cnt++;
        total_cnt++;
        if (dirty !== 8'h40) $display("FAIL post_reset_dirty got %h want 40", dirty);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        inp = 16'h0000;
        wr_en = 1'b0;
        wr_line = 3'd0;
        rd_line_a = 3'd0;
        rd_line_b = 3'd0;
        clr = 1'b0;
        test_reset();
        test_write_bypass();
        test_fill_dual_read();
        test_clear();
        test_ignored_while_busy();
        test_priority_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
